mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: LINE_W, default 128, cache-line width in bits; ADDR_W, default 28, line-address width; STARVE_LIMIT, default 4, maximum consecutive dcache grants while icache waits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ic_req_valid  input  1  icache line-refill request.
REQ-005 ic_req_ready  output  1  icache request accepted this cycle.
REQ-006 ic_req_addr  input  ADDR_W  icache line address.
REQ-007 ic_resp_valid  output  1  one-cycle pulse; ic_resp_data is valid.
REQ-008 ic_resp_data  output  LINE_W  refill line for icache.
REQ-009 dc_req_valid  input  1  dcache request (refill or writeback).
REQ-010 dc_req_ready  output  1  dcache request accepted this cycle.
REQ-011 dc_req_rw  input  1  1 = writeback, 0 = refill.
REQ-012 dc_req_addr  input  ADDR_W  dcache line address.
REQ-013 dc_req_wdata  input  LINE_W  writeback line.
REQ-014 dc_resp_valid  output  1  one-cycle pulse: refill data or write acknowledge.
REQ-015 dc_resp_data  output  LINE_W  refill line; zero for a write acknowledge.
REQ-016 mem_req_valid  output  1  request to backing memory.
REQ-017 mem_req_ready  input  1  memory accepts the request.
REQ-018 mem_req_rw, mem_req_addr, mem_req_wdata  output  1/ADDR_W/LINE_W  forwarded request fields.
REQ-019 mem_resp_valid  input  1  memory read data valid.
REQ-020 mem_resp_data  input  LINE_W  memory read data.
REQ-021 busy  output  1  high in any state other than IDLE.
REQ-022 proto_err  output  1  sticky; set on an unexpected memory response.

Function
REQ-023 The FSM SHALL have three states: IDLE, ISSUE and WAIT_RESP.
REQ-024 In IDLE, exactly one xx_req_ready SHALL be asserted, combinationally, for the winning valid requester; no ready SHALL be asserted in any other state.
REQ-025 Arbitration: dcache wins, except icache wins when both are valid and streak == STARVE_LIMIT.
REQ-026 streak SHALL increment, saturating, on a dcache grant while ic_req_valid is high; it SHALL clear on an icache grant.
REQ-027 On acceptance, owner, rw, addr and wdata SHALL be registered, and the next state SHALL be ISSUE.
REQ-028 In ISSUE, mem_req_valid SHALL be high, with fields driven from registers and held stable until mem_req_ready.
REQ-029 ISSUE with a write handshake SHALL go to IDLE, and dc_resp_valid SHALL pulse in the next cycle with dc_resp_data = 0.
REQ-030 ISSUE with a read handshake SHALL go to WAIT_RESP.
REQ-031 In WAIT_RESP, mem_resp_valid SHALL register mem_resp_data into the owner's resp_data, pulse the owner's resp_valid one cycle later, and return the FSM to IDLE.
REQ-032 Minimum request-accept to resp_valid latency SHALL be 3 cycles (memory ready and response each in the first cycle).
REQ-033 A new request SHALL be accepted in the same cycle as the resp_valid pulse, giving one transaction per 3 cycles best case.
REQ-034 mem_resp_valid in IDLE or ISSUE SHALL set proto_err and SHALL otherwise be ignored.
REQ-035 proto_err SHALL clear only on reset.
REQ-036 A resp_data register SHALL hold its last value between pulses.

Reset
REQ-037 Asserting reset SHALL immediately force: state IDLE, streak 0, proto_err 0, all valid/ready outputs 0, all data/address outputs 0.
REQ-038 Reset asserted mid-transaction SHALL drop the transaction, with no response issued afterward.
REQ-039 A stale memory response after reset deassertion SHALL set proto_err.

Structure
REQ-040 State encodings and the LINE_W/ADDR_W defaults SHALL reside in the shared const.vh.
REQ-041 The block SHALL be a single module with no sub-modules; registers MAY use the existing REGISTER_R/REGISTER_R_CE primitives.

Verification
REQ-042 Icache read 0x0000010, mem_req_ready and mem_resp_valid (data 0xA5..A5) each asserted the cycle after request -> ic_resp_valid pulses 3 cycles after acceptance with data 0xA5..A5; dc_resp_valid stays 0.
REQ-043 Both valid simultaneously, streak 0 -> dcache granted first, icache granted in the first IDLE cycle after the dcache transaction completes.
REQ-044 dc_req_valid held high with reads, ic_req_valid high throughout -> exactly 4 dcache grants, then 1 icache grant, then streak restarts.
REQ-045 dcache write, addr 0x0000020, wdata 0x1234, mem_req_ready delayed 5 cycles -> mem_req fields stable all 5 cycles; dc_resp_valid pulses with data 0 one cycle after the handshake.
REQ-046 reset asserted while in WAIT_RESP, then mem_resp_valid after release -> no resp_valid pulse; proto_err = 1; busy = 0.
REQ-047 mem_resp_valid asserted in IDLE -> proto_err = 1 and held until reset.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the icache/dcache memory arbiter.
//   - default line and line-address widths and the default starvation limit
//   - FSM state and transaction-owner encodings
//   - streak counter width helper
package mem_arbiter_pkg;

   localparam int unsigned LINE_W_DEF       = 128;
   localparam int unsigned ADDR_W_DEF       = 28;
   localparam int unsigned STARVE_LIMIT_DEF = 4;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StIssue    = 2'd1,
      StWaitResp = 2'd2
   } state_e;

   typedef enum logic {
      OwnIc = 1'b0,
      OwnDc = 1'b1
   } owner_e;

   // Bits needed to count 0..limit inclusive.
   function automatic int unsigned streak_width(input int unsigned limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache refills and dcache refills/writebacks onto a
// single backing-memory port, one transaction in flight at a time.
//
// Ports:
//   clk, reset (async, active-low)
//   ic_req_valid/ready/addr            icache refill request
//   ic_resp_valid/data                 icache refill response (1-cycle pulse)
//   dc_req_valid/ready/rw/addr/wdata   dcache request (rw=1 writeback)
//   dc_resp_valid/data                 dcache response (data 0 on write ack)
//   mem_req_valid/ready/rw/addr/wdata  request to backing memory
//   mem_resp_valid/data                read data from backing memory
//   busy                               FSM not idle
//   proto_err                          sticky: memory response when none expected
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned LINE_W       = LINE_W_DEF,
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              ic_req_valid,
   output logic              ic_req_ready,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_resp_valid,
   output logic [LINE_W-1:0] ic_resp_data,

   input  logic              dc_req_valid,
   output logic              dc_req_ready,
   input  logic              dc_req_rw,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic [LINE_W-1:0] dc_req_wdata,
   output logic              dc_resp_valid,
   output logic [LINE_W-1:0] dc_resp_data,

   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [LINE_W-1:0] mem_req_wdata,
   input  logic              mem_resp_valid,
   input  logic [LINE_W-1:0] mem_resp_data,

   output logic              busy,
   output logic              proto_err
);

   localparam int unsigned          STREAK_W   = streak_width(STARVE_LIMIT);
   localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(STARVE_LIMIT);

   state_e              state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   owner_e              owner_q, owner_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic                ic_resp_valid_q, ic_resp_valid_d;
   logic [LINE_W-1:0]   ic_resp_data_q, ic_resp_data_d;
   logic                dc_resp_valid_q, dc_resp_valid_d;
   logic [LINE_W-1:0]   dc_resp_data_q, dc_resp_data_d;
   logic                proto_err_q, proto_err_d;

   logic                dc_win;
   logic                ic_grant, dc_grant;

   // dcache has priority unless the icache has been passed over too often.
   assign dc_win = dc_req_valid && !(ic_req_valid && (streak_q == STREAK_MAX));

   always_comb begin
      state_d         = state_q;
      streak_d        = streak_q;
      owner_d         = owner_q;
      rw_d            = rw_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      ic_resp_valid_d = 1'b0;
      dc_resp_valid_d = 1'b0;
      ic_resp_data_d  = ic_resp_data_q;
      dc_resp_data_d  = dc_resp_data_q;
      proto_err_d     = proto_err_q;
      ic_grant        = 1'b0;
      dc_grant        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (dc_win) begin
               dc_grant = 1'b1;
               owner_d  = OwnDc;
               rw_d     = dc_req_rw;
               addr_d   = dc_req_addr;
               wdata_d  = dc_req_wdata;
               state_d  = StIssue;
               // Only count grants that actually made the icache wait.
               if (ic_req_valid && (streak_q != STREAK_MAX)) begin
                  streak_d = streak_q + 1'b1;
               end
            end else if (ic_req_valid) begin
               ic_grant = 1'b1;
               owner_d  = OwnIc;
               rw_d     = 1'b0;
               addr_d   = ic_req_addr;
               wdata_d  = '0;
               streak_d = '0;
               state_d  = StIssue;
            end
         end

         StIssue: begin
            if (mem_req_ready) begin
               if (rw_q) begin
                  // Writes complete on the handshake; only the dcache writes.
                  dc_resp_valid_d = 1'b1;
                  dc_resp_data_d  = '0;
                  state_d         = StIdle;
               end else begin
                  state_d = StWaitResp;
               end
            end
         end

         StWaitResp: begin
            if (mem_resp_valid) begin
               if (owner_q == OwnDc) begin
                  dc_resp_valid_d = 1'b1;
                  dc_resp_data_d  = mem_resp_data;
               end else begin
                  ic_resp_valid_d = 1'b1;
                  ic_resp_data_d  = mem_resp_data;
               end
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase

      if (mem_resp_valid && (state_q != StWaitResp)) begin
         proto_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= StIdle;
         streak_q        <= '0;
         owner_q         <= OwnIc;
         rw_q            <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         ic_resp_valid_q <= 1'b0;
         ic_resp_data_q  <= '0;
         dc_resp_valid_q <= 1'b0;
         dc_resp_data_q  <= '0;
         proto_err_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         streak_q        <= streak_d;
         owner_q         <= owner_d;
         rw_q            <= rw_d;
         addr_q          <= addr_d;
         wdata_q         <= wdata_d;
         ic_resp_valid_q <= ic_resp_valid_d;
         ic_resp_data_q  <= ic_resp_data_d;
         dc_resp_valid_q <= dc_resp_valid_d;
         dc_resp_data_q  <= dc_resp_data_d;
         proto_err_q     <= proto_err_d;
      end
   end

   // Readies are combinational from the inputs; mask them while reset is held
   // since the state register alone already reads as idle then.
   assign ic_req_ready  = ic_grant && reset;
   assign dc_req_ready  = dc_grant && reset;

   assign ic_resp_valid = ic_resp_valid_q;
   assign ic_resp_data  = ic_resp_data_q;
   assign dc_resp_valid = dc_resp_valid_q;
   assign dc_resp_data  = dc_resp_data_q;

   assign mem_req_valid = (state_q == StIssue);
   assign mem_req_rw    = rw_q;
   assign mem_req_addr  = addr_q;
   assign mem_req_wdata = wdata_q;

   assign busy          = (state_q != StIdle);
   assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Inputs are driven 1 time unit after each rising edge; checks follow after a
// further settle delay, well away from the next edge.
module tb_mem_arbiter;

   localparam int unsigned LINE_W = 128;
   localparam int unsigned ADDR_W = 28;

   logic              clk;
   logic              reset;
   logic              ic_req_valid;
   logic              ic_req_ready;
   logic [ADDR_W-1:0] ic_req_addr;
   logic              ic_resp_valid;
   logic [LINE_W-1:0] ic_resp_data;
   logic              dc_req_valid;
   logic              dc_req_ready;
   logic              dc_req_rw;
   logic [ADDR_W-1:0] dc_req_addr;
   logic [LINE_W-1:0] dc_req_wdata;
   logic              dc_resp_valid;
   logic [LINE_W-1:0] dc_resp_data;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_rw;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [LINE_W-1:0] mem_req_wdata;
   logic              mem_resp_valid;
   logic [LINE_W-1:0] mem_resp_data;
   logic              busy;
   logic              proto_err;

   int tests_run;
   int tests_failed;

   mem_arbiter #(
      .LINE_W       (LINE_W),
      .ADDR_W       (ADDR_W),
      .STARVE_LIMIT (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ic_req_valid   (ic_req_valid),
      .ic_req_ready   (ic_req_ready),
      .ic_req_addr    (ic_req_addr),
      .ic_resp_valid  (ic_resp_valid),
      .ic_resp_data   (ic_resp_data),
      .dc_req_valid   (dc_req_valid),
      .dc_req_ready   (dc_req_ready),
      .dc_req_rw      (dc_req_rw),
      .dc_req_addr    (dc_req_addr),
      .dc_req_wdata   (dc_req_wdata),
      .dc_resp_valid  (dc_resp_valid),
      .dc_resp_data   (dc_resp_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_rw     (mem_req_rw),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .busy           (busy),
      .proto_err      (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                      input logic [LINE_W-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Runs one granted read from the current settled IDLE cycle to the
   // response pulse, with memory ready and response each on first chance.
   task automatic serve_read(input string tag, input logic exp_dc,
                             input logic [LINE_W-1:0] data);
      chk({tag, " dc_ready"}, LINE_W'(dc_req_ready), LINE_W'(exp_dc));
      chk({tag, " ic_ready"}, LINE_W'(ic_req_ready), LINE_W'(!exp_dc));
      cyc();
      mem_req_ready = 1'b1;
      #1;
      chk({tag, " issue valid"}, LINE_W'(mem_req_valid), LINE_W'(1'b1));
      chk({tag, " issue rw"}, LINE_W'(mem_req_rw), LINE_W'(1'b0));
      cyc();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = data;
      #1;
      chk({tag, " wait busy"}, LINE_W'(busy), LINE_W'(1'b1));
      cyc();
      mem_resp_valid = 1'b0;
      #1;
      chk({tag, " ic_resp_valid"}, LINE_W'(ic_resp_valid), LINE_W'(!exp_dc));
      chk({tag, " dc_resp_valid"}, LINE_W'(dc_resp_valid), LINE_W'(exp_dc));
      chk({tag, " resp_data"}, exp_dc ? dc_resp_data : ic_resp_data, data);
   endtask

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      reset          = 1'b0;
      ic_req_valid   = 1'b1;
      ic_req_addr    = '0;
      dc_req_valid   = 1'b0;
      dc_req_rw      = 1'b0;
      dc_req_addr    = '0;
      dc_req_wdata   = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;

      // Reset state, with a request pending to show readies are masked.
      cyc();
      cyc();
      chk("rst busy", LINE_W'(busy), '0);
      chk("rst proto_err", LINE_W'(proto_err), '0);
      chk("rst ic_ready", LINE_W'(ic_req_ready), '0);
      chk("rst mem_req_valid", LINE_W'(mem_req_valid), '0);
      chk("rst mem_req_addr", LINE_W'(mem_req_addr), '0);
      chk("rst ic_resp_valid", LINE_W'(ic_resp_valid), '0);
      chk("rst dc_resp_data", dc_resp_data, '0);
      ic_req_valid = 1'b0;
      reset        = 1'b1;
      cyc();

      // Icache read with minimum latency.
      ic_req_valid = 1'b1;
      ic_req_addr  = 28'h0000010;
      #1;
      serve_read("ic_read", 1'b0, {16{8'hA5}});
      ic_req_valid = 1'b0;
      chk("ic_read dc_resp_valid", LINE_W'(dc_resp_valid), '0);
      cyc();
      chk("ic_read pulse ends", LINE_W'(ic_resp_valid), '0);
      chk("ic_read data held", ic_resp_data, {16{8'hA5}});
      chk("ic_read proto_err", LINE_W'(proto_err), '0);

      // Both valid with streak 0: dcache first, icache right after.
      ic_req_valid = 1'b1;
      ic_req_addr  = 28'h0000030;
      dc_req_valid = 1'b1;
      dc_req_rw    = 1'b0;
      dc_req_addr  = 28'h0000040;
      #1;
      serve_read("both dc", 1'b1, LINE_W'(128'h5A));
      dc_req_valid = 1'b0;
      #1;
      chk("both ic next", LINE_W'(ic_req_ready), LINE_W'(1'b1));
      serve_read("both ic", 1'b0, LINE_W'(128'h77));
      ic_req_valid = 1'b0;
      cyc();

      // Starvation: four dcache grants, one icache grant, then dcache again.
      ic_req_valid = 1'b1;
      dc_req_valid = 1'b1;
      #1;
      serve_read("starve dc1", 1'b1, LINE_W'(128'hD1));
      serve_read("starve dc2", 1'b1, LINE_W'(128'hD2));
      serve_read("starve dc3", 1'b1, LINE_W'(128'hD3));
      serve_read("starve dc4", 1'b1, LINE_W'(128'hD4));
      serve_read("starve ic", 1'b0, LINE_W'(128'hC1));
      serve_read("starve dc5", 1'b1, LINE_W'(128'hD5));
      ic_req_valid = 1'b0;
      dc_req_valid = 1'b0;
      cyc();

      // Writeback with memory stalling five cycles.
      dc_req_valid = 1'b1;
      dc_req_rw    = 1'b1;
      dc_req_addr  = 28'h0000020;
      dc_req_wdata = LINE_W'(128'h1234);
      #1;
      chk("wr dc_ready", LINE_W'(dc_req_ready), LINE_W'(1'b1));
      cyc();
      dc_req_valid = 1'b0;
      dc_req_rw    = 1'b0;
      dc_req_addr  = '0;
      dc_req_wdata = '0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("wr stall valid", LINE_W'(mem_req_valid), LINE_W'(1'b1));
         chk("wr stall rw", LINE_W'(mem_req_rw), LINE_W'(1'b1));
         chk("wr stall addr", LINE_W'(mem_req_addr), LINE_W'(28'h0000020));
         chk("wr stall wdata", mem_req_wdata, LINE_W'(128'h1234));
         chk("wr stall no ack", LINE_W'(dc_resp_valid), '0);
         cyc();
      end
      mem_req_ready = 1'b1;
      #1;
      chk("wr hs valid", LINE_W'(mem_req_valid), LINE_W'(1'b1));
      cyc();
      mem_req_ready = 1'b0;
      #1;
      chk("wr ack valid", LINE_W'(dc_resp_valid), LINE_W'(1'b1));
      chk("wr ack data", dc_resp_data, '0);
      chk("wr ack idle", LINE_W'(busy), '0);
      cyc();
      chk("wr ack ends", LINE_W'(dc_resp_valid), '0);

      // Reset during WAIT_RESP, then a stale memory response.
      ic_req_valid = 1'b1;
      ic_req_addr  = 28'h0000050;
      #1;
      chk("rstmid ic_ready", LINE_W'(ic_req_ready), LINE_W'(1'b1));
      cyc();
      ic_req_valid  = 1'b0;
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      #1;
      chk("rstmid in wait", LINE_W'(busy && !mem_req_valid), LINE_W'(1'b1));
      reset = 1'b0;
      #1;
      chk("rstmid busy", LINE_W'(busy), '0);
      chk("rstmid mem_req_addr", LINE_W'(mem_req_addr), '0);
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      mem_resp_valid = 1'b1;
      mem_resp_data  = LINE_W'(128'hEE);
      #1;
      chk("stale pre proto_err", LINE_W'(proto_err), '0);
      cyc();
      mem_resp_valid = 1'b0;
      #1;
      chk("stale proto_err", LINE_W'(proto_err), LINE_W'(1'b1));
      chk("stale no ic pulse", LINE_W'(ic_resp_valid), '0);
      chk("stale no dc pulse", LINE_W'(dc_resp_valid), '0);
      chk("stale busy", LINE_W'(busy), '0);
      chk("stale ic data", ic_resp_data, '0);
      cyc();
      chk("stale later ic", LINE_W'(ic_resp_valid), '0);

      // Response in IDLE sets a sticky error cleared only by reset.
      reset = 1'b0;
      #1;
      chk("idle err cleared", LINE_W'(proto_err), '0);
      cyc();
      reset = 1'b1;
      cyc();
      mem_resp_valid = 1'b1;
      cyc();
      mem_resp_valid = 1'b0;
      #1;
      chk("idle err set", LINE_W'(proto_err), LINE_W'(1'b1));
      cyc();
      cyc();
      cyc();
      chk("idle err sticky", LINE_W'(proto_err), LINE_W'(1'b1));
      reset = 1'b0;
      #1;
      chk("idle err reset", LINE_W'(proto_err), '0);
      reset = 1'b1;
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
